// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB4 completer with a built-in byte-strobed word memory. It is a generic
// scratch/register memory that sits behind the APB bridge. The data width and
// memory depth are parameters. A programmable number of wait states is
// inserted into every access phase. Misaligned and out-of-range addresses
// return SLVERR. A transfer is abandoned if the requester drops p_sel
// mid-transfer.
//
// Parameters:
//   DataWidth  : bus/word width in bits (8, 16, 32 or 64)
//   NumWords   : memory depth in words (power of 2, >= 2)
//   AddrBits   : width of p_addr (>= log2(DataWidth/8) + log2(NumWords))
//   WaitStates : p_ready-low cycles per access phase (0..15)
//
// Ports:
//   p_clk      in   clock, rising edge
//   p_resetn   in   asynchronous active-low reset
//   p_addr     in   byte address
//   p_sel      in   select
//   p_enable   in   access-phase indicator
//   p_write    in   1 = write, 0 = read
//   p_wdata    in   write data
//   p_strb     in   write byte strobes (ignored on reads)
//   p_rdata    out  read data (zero unless an OKAY read completes)
//   p_ready    out  transfer completes in this cycle
//   p_slverr   out  error response, qualified by p_ready
// -----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int DataWidth  = 32,
    parameter int NumWords   = 64,
    parameter int AddrBits   = 32,
    parameter int WaitStates = 0
) (
    input  logic                   p_clk,
    input  logic                   p_resetn,
    input  logic [AddrBits-1:0]    p_addr,
    input  logic                   p_sel,
    input  logic                   p_enable,
    input  logic                   p_write,
    input  logic [DataWidth-1:0]   p_wdata,
    input  logic [DataWidth/8-1:0] p_strb,
    output logic [DataWidth-1:0]   p_rdata,
    output logic                   p_ready,
    output logic                   p_slverr
);

    localparam int NB  = DataWidth / 8;      // byte lanes
    localparam int LB  = $clog2(NB);         // byte-offset bits
    localparam int IW  = $clog2(NumWords);   // word-index bits
    localparam int TOP = LB + IW;            // first address bit above the index

    localparam logic [3:0] WAIT_INIT = 4'(WaitStates);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   capture;

    logic [IW-1:0]          idx_q;
    logic                   err_q;
    logic                   write_q;
    logic [NB-1:0]          strb_q;
    logic [DataWidth-1:0]   wdata_q;

    logic [DataWidth-1:0]   mem [NumWords];

    // -------------------------------------------------------------------------
    // Address decode. It is used only when the setup phase is captured, so
    // p_addr never reaches an output combinationally.
    // -------------------------------------------------------------------------
    logic [IW-1:0] idx;
    logic          misaligned;
    logic          range_err;

    assign idx = p_addr[TOP-1:LB];

    generate
        if (LB > 0) begin : g_misaligned
            assign misaligned = |p_addr[LB-1:0];
        end else begin : g_no_misaligned
            assign misaligned = 1'b0;
        end

        // Any bit above the index makes the address out of range. There is
        // no wrap, so a high address can never alias onto a real word.
        if (AddrBits > TOP) begin : g_range
            assign range_err = |p_addr[AddrBits-1:TOP];
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM next state and wait counter
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                // p_enable without a prior setup is ignored.
                if (p_sel && !p_enable) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!p_sel) begin
                    // Abort: drop the transfer without a response or a write.
                    state_d = IDLE;
                end else if (!p_enable) begin
                    // A repeated setup replaces the pending transfer.
                    capture = 1'b1;
                    cnt_d   = WAIT_INIT;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= idx;
                err_q   <= misaligned | range_err;
                write_q <= p_write;
                strb_q  <= p_strb;
                wdata_q <= p_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response
    // -------------------------------------------------------------------------
    logic mem_we;
    logic rd_en;

    assign p_ready  = (state_q == ACCESS) && p_sel && p_enable && (cnt_q == 4'd0);
    assign p_slverr = p_ready & err_q;
    assign mem_we   = p_ready & write_q & ~err_q;
    assign rd_en    = p_ready & ~write_q & ~err_q;
    assign p_rdata  = rd_en ? mem[idx_q] : '0;

    // -------------------------------------------------------------------------
    // Memory
    // -------------------------------------------------------------------------
    // NOTE: the memory must read back as zero after reset, so it is built
    // from reset flops rather than an inferred RAM macro.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            for (int i = 0; i < NumWords; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (strb_q[k]) begin
                    mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Directed bench for apb_slave_mem. Four instances share one APB bus, and
// each has its own p_sel:
//   W0  : 32-bit, 64 words, 0 wait states
//   W2  : 32-bit, 64 words, 2 wait states
//   W3  : 32-bit, 64 words, 3 wait states
//   D64 : 64-bit, 64 words, 0 wait states
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

    localparam int W0  = 0;
    localparam int W2  = 1;
    localparam int W3  = 2;
    localparam int D64 = 3;

    logic        p_clk;
    logic        p_resetn;
    logic [31:0] p_addr;
    logic [3:0]  sel;
    logic        p_enable;
    logic        p_write;
    logic [63:0] p_wdata;
    logic [7:0]  p_strb;

    logic [31:0] rdata0, rdata1, rdata2;
    logic [63:0] rdata3;
    logic [3:0]  ready;
    logic [3:0]  slverr;

    int tests = 0;
    int fails = 0;

    apb_slave_mem #(.DataWidth(32), .NumWords(64), .AddrBits(32), .WaitStates(0)) u_w0 (
        .p_clk(p_clk), .p_resetn(p_resetn), .p_addr(p_addr), .p_sel(sel[W0]),
        .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata[31:0]),
        .p_strb(p_strb[3:0]), .p_rdata(rdata0), .p_ready(ready[W0]), .p_slverr(slverr[W0])
    );

    apb_slave_mem #(.DataWidth(32), .NumWords(64), .AddrBits(32), .WaitStates(2)) u_w2 (
        .p_clk(p_clk), .p_resetn(p_resetn), .p_addr(p_addr), .p_sel(sel[W2]),
        .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata[31:0]),
        .p_strb(p_strb[3:0]), .p_rdata(rdata1), .p_ready(ready[W2]), .p_slverr(slverr[W2])
    );

    apb_slave_mem #(.DataWidth(32), .NumWords(64), .AddrBits(32), .WaitStates(3)) u_w3 (
        .p_clk(p_clk), .p_resetn(p_resetn), .p_addr(p_addr), .p_sel(sel[W3]),
        .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata[31:0]),
        .p_strb(p_strb[3:0]), .p_rdata(rdata2), .p_ready(ready[W3]), .p_slverr(slverr[W3])
    );

    apb_slave_mem #(.DataWidth(64), .NumWords(64), .AddrBits(32), .WaitStates(0)) u_d64 (
        .p_clk(p_clk), .p_resetn(p_resetn), .p_addr(p_addr), .p_sel(sel[D64]),
        .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata),
        .p_strb(p_strb), .p_rdata(rdata3), .p_ready(ready[D64]), .p_slverr(slverr[D64])
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [63:0] get_rdata(input int d);
        case (d)
            W0:      return {32'h0, rdata0};
            W2:      return {32'h0, rdata1};
            W3:      return {32'h0, rdata2};
            default: return rdata3;
        endcase
    endfunction

    // Runs one complete transfer on instance d. The setup phase starts one
    // cycle after the call, so consecutive calls are back-to-back. The bus is
    // left in the access phase; bus_idle releases it.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [7:0] sb,
                            output logic [63:0] rd, output logic err, output int waits);
        bit done;
        done = 1'b0;
        @(posedge p_clk); #1;
        sel      = '0;
        sel[d]   = 1'b1;
        p_enable = 1'b0;
        p_write  = wr;
        p_addr   = addr;
        p_wdata  = wd;
        p_strb   = sb;
        @(negedge p_clk);
        tests++;
        if (ready[d] !== 1'b0) begin
            fails++;
            $display("FAIL setup_ready dut%0d addr %h: got %b want 0", d, addr, ready[d]);
        end
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        waits = 0;
        rd    = '0;
        err   = 1'b0;
        while (!done) begin
            @(negedge p_clk);
            if (ready[d] === 1'b1) begin
                done = 1'b1;
                rd   = get_rdata(d);
                err  = slverr[d];
            end else begin
                waits++;
                if (waits > 20) begin
                    tests++;
                    fails++;
                    $display("FAIL ready_timeout dut%0d addr %h: no p_ready in 20 cycles", d, addr);
                    done = 1'b1;
                end else begin
                    @(posedge p_clk); #1;
                end
            end
        end
    endtask

    task automatic bus_idle();
        @(posedge p_clk); #1;
        sel      = '0;
        p_enable = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        sel      = '0;
        p_enable = 1'b0;
        p_write  = 1'b0;
        p_addr   = '0;
        p_wdata  = '0;
        p_strb   = '0;
        p_resetn = 1'b0;
        #12;
        tests++; if (ready !== 4'b0000)  begin fails++; $display("FAIL reset_ready: got %b want 0000", ready); end
        tests++; if (slverr !== 4'b0000) begin fails++; $display("FAIL reset_slverr: got %b want 0000", slverr); end
        tests++; if ({rdata0, rdata1, rdata2, rdata3} !== 160'h0) begin
            fails++; $display("FAIL reset_rdata: got %h %h %h %h want 0", rdata0, rdata1, rdata2, rdata3);
        end
        @(negedge p_clk);
        p_resetn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [63:0] rd;
        logic        err;
        int          waits;
        apb_xfer(W0, 1'b1, 32'h10, 64'hDEADBEEF, 8'hF, rd, err, waits);
        tests++; if (waits !== 0)   begin fails++; $display("FAIL wr_full_waits: got %0d want 0", waits); end
        tests++; if (err !== 1'b0)  begin fails++; $display("FAIL wr_full_slverr: got %b want 0", err); end
        apb_xfer(W0, 1'b0, 32'h10, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_full: got %h want deadbeef", rd[31:0]); end
        tests++; if (err !== 1'b0)  begin fails++; $display("FAIL rd_full_slverr: got %b want 0", err); end
        tests++; if (waits !== 0)   begin fails++; $display("FAIL rd_full_waits: got %0d want 0", waits); end
        apb_xfer(W0, 1'b1, 32'h10, 64'h11223344, 8'h5, rd, err, waits);
        apb_xfer(W0, 1'b0, 32'h10, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd[31:0] !== 32'hDE22BE44) begin fails++; $display("FAIL rd_strb5: got %h want de22be44", rd[31:0]); end
        apb_xfer(W0, 1'b1, 32'h10, 64'hFFFFFFFF, 8'h0, rd, err, waits);
        tests++; if (err !== 1'b0)  begin fails++; $display("FAIL wr_strb0_slverr: got %b want 0", err); end
        apb_xfer(W0, 1'b0, 32'h10, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd[31:0] !== 32'hDE22BE44) begin fails++; $display("FAIL rd_strb0: got %h want de22be44", rd[31:0]); end
        bus_idle();

        // p_enable without a setup phase must be ignored.
        @(posedge p_clk); #1;
        sel[W0]  = 1'b1;
        p_enable = 1'b1;
        p_write  = 1'b0;
        p_addr   = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge p_clk);
            tests++; if (ready[W0] !== 1'b0) begin fails++; $display("FAIL idle_enable_ready cycle %0d: got %b want 0", i, ready[W0]); end
        end
        bus_idle();
        apb_xfer(W0, 1'b0, 32'h10, 64'h0, 8'h0, rd, err, waits);
        tests++; if (waits !== 0 || rd[31:0] !== 32'hDE22BE44) begin
            fails++; $display("FAIL rd_after_idle_enable: got %h waits %0d want de22be44 waits 0", rd[31:0], waits);
        end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [63:0] rd;
        logic        err;
        int          waits;
        apb_xfer(W2, 1'b1, 32'h04, 64'hCAFE0004, 8'hF, rd, err, waits);
        tests++; if (waits !== 2) begin fails++; $display("FAIL ws_write_waits: got %0d want 2", waits); end
        apb_xfer(W2, 1'b0, 32'h04, 64'h0, 8'h0, rd, err, waits);
        tests++; if (waits !== 2) begin fails++; $display("FAIL ws_read_waits: got %0d want 2", waits); end
        tests++; if (rd[31:0] !== 32'hCAFE0004 || err !== 1'b0) begin
            fails++; $display("FAIL ws_read_data: got %h err %b want cafe0004 err 0", rd[31:0], err);
        end
        bus_idle();
    endtask

    task automatic test_errors();
        logic [63:0] rd;
        logic        err;
        int          waits;
        apb_xfer(W0, 1'b1, 32'h00, 64'h55AA55AA, 8'hF, rd, err, waits);
        apb_xfer(W0, 1'b1, 32'h100, 64'hCAFEF00D, 8'hF, rd, err, waits);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL range_wr_slverr: got %b want 1", err); end
        apb_xfer(W0, 1'b0, 32'h00, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd[31:0] !== 32'h55AA55AA || err !== 1'b0) begin
            fails++; $display("FAIL range_wr_no_alias: got %h err %b want 55aa55aa err 0", rd[31:0], err);
        end
        apb_xfer(W0, 1'b0, 32'h02, 64'h0, 8'h0, rd, err, waits);
        tests++; if (err !== 1'b1)      begin fails++; $display("FAIL misaligned_slverr: got %b want 1", err); end
        tests++; if (rd[31:0] !== 32'h0) begin fails++; $display("FAIL misaligned_rdata: got %h want 0", rd[31:0]); end
        apb_xfer(W0, 1'b0, 32'h80000010, 64'h0, 8'h0, rd, err, waits);
        tests++; if (err !== 1'b1 || rd[31:0] !== 32'h0) begin
            fails++; $display("FAIL high_addr_rd: got %h err %b want 0 err 1", rd[31:0], err);
        end
        apb_xfer(W0, 1'b1, 32'h0FC, 64'h0BADCAFE, 8'hF, rd, err, waits);
        apb_xfer(W0, 1'b0, 32'h0FC, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd[31:0] !== 32'h0BADCAFE || err !== 1'b0) begin
            fails++; $display("FAIL last_word_rd: got %h err %b want 0badcafe err 0", rd[31:0], err);
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [63:0] rd;
        logic        err;
        int          waits;
        apb_xfer(W3, 1'b1, 32'h20, 64'h01020304, 8'hF, rd, err, waits);
        tests++; if (waits !== 3) begin fails++; $display("FAIL abort_pre_waits: got %0d want 3", waits); end
        bus_idle();
        // Setup, one wait cycle, then drop p_sel.
        @(posedge p_clk); #1;
        sel[W3]  = 1'b1;
        p_enable = 1'b0;
        p_write  = 1'b1;
        p_addr   = 32'h20;
        p_wdata  = 64'hA5A5A5A5;
        p_strb   = 8'hF;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        @(negedge p_clk);
        tests++; if (ready[W3] !== 1'b0) begin fails++; $display("FAIL abort_wait_ready: got %b want 0", ready[W3]); end
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge p_clk);
            tests++; if (ready[W3] !== 1'b0) begin fails++; $display("FAIL abort_no_ready cycle %0d: got %b want 0", i, ready[W3]); end
        end
        apb_xfer(W3, 1'b0, 32'h20, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd[31:0] !== 32'h01020304 || err !== 1'b0) begin
            fails++; $display("FAIL abort_old_value: got %h err %b want 01020304 err 0", rd[31:0], err);
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic        err;
        int          waits;
        apb_xfer(W3, 1'b1, 32'h14, 64'h12345678, 8'hF, rd, err, waits);
        bus_idle();
        @(posedge p_clk); #1;
        sel[W3]  = 1'b1;
        p_enable = 1'b0;
        p_write  = 1'b0;
        p_addr   = 32'h14;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        repeat (3) @(posedge p_clk);
        #1;
        tests++; if (ready[W3] !== 1'b1 || rdata2 !== 32'h12345678) begin
            fails++; $display("FAIL pre_reset_rd: got ready %b data %h want 1 12345678", ready[W3], rdata2);
        end
        p_resetn = 1'b0;
        #1;
        tests++; if (ready[W3] !== 1'b0 || slverr[W3] !== 1'b0 || rdata2 !== 32'h0) begin
            fails++; $display("FAIL mid_reset_outputs: got ready %b slverr %b data %h want 0 0 0", ready[W3], slverr[W3], rdata2);
        end
        @(posedge p_clk); #1;
        sel      = '0;
        p_enable = 1'b0;
        @(negedge p_clk);
        p_resetn = 1'b1;
        apb_xfer(W3, 1'b0, 32'h14, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd[31:0] !== 32'h0 || err !== 1'b0 || waits !== 3) begin
            fails++; $display("FAIL post_reset_rd: got %h err %b waits %0d want 0 0 3", rd[31:0], err, waits);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd;
        logic        err;
        int          waits;
        apb_xfer(D64, 1'b1, 32'h08, 64'h0123456789ABCDEF, 8'hFF, rd, err, waits);
        tests++; if (err !== 1'b0 || waits !== 0) begin fails++; $display("FAIL b2b_wr: got err %b waits %0d want 0 0", err, waits); end
        apb_xfer(D64, 1'b0, 32'h08, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL b2b_rd: got %h want 0123456789abcdef", rd); end
        apb_xfer(D64, 1'b1, 32'h08, 64'hFFFFFFFFFFFFFFFF, 8'h0F, rd, err, waits);
        apb_xfer(D64, 1'b0, 32'h08, 64'h0, 8'h0, rd, err, waits);
        tests++; if (rd !== 64'h01234567FFFFFFFF) begin fails++; $display("FAIL d64_strb0f: got %h want 01234567ffffffff", rd); end
        apb_xfer(D64, 1'b0, 32'h0C, 64'h0, 8'h0, rd, err, waits);
        tests++; if (err !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL d64_misaligned: got %h err %b want 0 err 1", rd, err); end
        apb_xfer(D64, 1'b0, 32'h200, 64'h0, 8'h0, rd, err, waits);
        tests++; if (err !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL d64_range: got %h err %b want 0 err 1", rd, err); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge p_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
